// File: rtl/ysyx_210544_rtc_pkg.sv
// Shared constants for the RTC controller: register map, packed-time layout, FSM states.
// rtc_pack() builds the packed time word the calendar core consumes.
package ysyx_210544_rtc_pkg;

  localparam int BUS_64 = 64;

  localparam logic [1:0] ADDR_TIME     = 2'd0;
  localparam logic [1:0] ADDR_PRESCALE = 2'd1;
  localparam logic [1:0] ADDR_CTRL     = 2'd2;
  localparam logic [1:0] ADDR_ALARM    = 2'd3;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 6;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 16;

  localparam int SEC_OFF  = 0;
  localparam int MIN_OFF  = SEC_OFF + SEC_W;
  localparam int HOUR_OFF = MIN_OFF + MIN_W;
  localparam int DAY_OFF  = HOUR_OFF + HOUR_W;
  localparam int MON_OFF  = DAY_OFF + DAY_W;
  localparam int YEAR_OFF = MON_OFF + MON_W;
  localparam int TIME_W   = YEAR_OFF + YEAR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } rtc_state_t;

  function automatic logic [BUS_64-1:0] rtc_pack(
    input logic [YEAR_W-1:0] year,
    input logic [MON_W-1:0]  month,
    input logic [DAY_W-1:0]  day,
    input logic [HOUR_W-1:0] hour,
    input logic [MIN_W-1:0]  minute,
    input logic [SEC_W-1:0]  second
  );
    logic [BUS_64-1:0] v;
    v = '0;
    v[YEAR_OFF +: YEAR_W] = year;
    v[MON_OFF  +: MON_W]  = month;
    v[DAY_OFF  +: DAY_W]  = day;
    v[HOUR_OFF +: HOUR_W] = hour;
    v[MIN_OFF  +: MIN_W]  = minute;
    v[SEC_OFF  +: SEC_W]  = second;
    return v;
  endfunction

endpackage

// File: rtl/ysyx_210544_rtc_prescaler.sv
// Second-tick prescaler: tick is a same-cycle pulse when cnt hits prescale-1 while running.
// clear zeroes cnt and masks a coincident tick; run=0 freezes cnt.
module ysyx_210544_rtc_prescaler #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] prescale,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == (prescale - CNT_W'(1)));
  assign tick = run & wrap & ~clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ysyx_210544_rtc_ctrl.sv
// RTC controller: round-robin arbiter, IDLE->ACCESS->RESP register FSM, prescaler; response at N+2.
// One request in flight; req_ready stays low until the response is taken. Alarm logic under RTC_ALARM_EN.
module ysyx_210544_rtc_ctrl
  import ysyx_210544_rtc_pkg::*;
#(
  parameter int PRESCALE_RST = 100,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_wr,
  input  logic [3:0]        req_addr,
  input  logic [127:0]      req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [BUS_64-1:0] resp_rdata,
  input  logic [BUS_64-1:0] rtc_val,
  output logic              rtc_tick,
  output logic              rtc_load,
  output logic [BUS_64-1:0] rtc_load_val,
  output logic              alarm_irq
);

  rtc_state_t        state;
  logic              last_grant;
  logic              gnt_id;
  logic              hs;
  logic              sel_wr;
  logic [1:0]        sel_addr;
  logic [BUS_64-1:0] sel_wdata;
  logic              cur_id;
  logic              cur_wr;
  logic [1:0]        cur_addr;
  logic [TIME_W-1:0] cur_wdata;
  logic [CNT_W-1:0]  prescale;
  logic              run;
  logic              acc_wr;
  logic              cnt_clear;
  logic              alarm_en_rd;
  logic [TIME_W-1:0] alarm_rd;
  logic [BUS_64-1:0] rd_mux;
  logic              unused_bits;

  // Both valid: alternate away from the last winner; otherwise serve whoever asks.
  assign gnt_id    = (&req_valid) ? ~last_grant : req_valid[1];
  assign req_ready = (rst && state == ST_IDLE && |req_valid) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign hs        = |(req_valid & req_ready);
  assign sel_wr    = req_wr[gnt_id];
  assign sel_addr  = gnt_id ? req_addr[3:2] : req_addr[1:0];
  assign sel_wdata = gnt_id ? req_wdata[127:64] : req_wdata[63:0];

  assign acc_wr    = (state == ST_ACCESS) && cur_wr;
  assign cnt_clear = acc_wr && (cur_addr == ADDR_TIME || cur_addr == ADDR_PRESCALE);

  always_comb begin
    rd_mux = '0;
    if (!cur_wr) begin
      case (cur_addr)
        ADDR_TIME:     rd_mux = rtc_val;
        ADDR_PRESCALE: rd_mux[CNT_W-1:0] = prescale;
        ADDR_CTRL:     rd_mux[1:0] = {alarm_en_rd, run};
        default:       rd_mux[TIME_W-1:0] = alarm_rd;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      cur_wr       <= 1'b0;
      cur_addr     <= '0;
      cur_wdata    <= '0;
      resp_valid   <= 1'b0;
      resp_id      <= 1'b0;
      resp_rdata   <= '0;
      rtc_load     <= 1'b0;
      rtc_load_val <= '0;
      prescale     <= CNT_W'(PRESCALE_RST);
      run          <= 1'b0;
    end else begin
      rtc_load <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            cur_id     <= gnt_id;
            cur_wr     <= sel_wr;
            cur_addr   <= sel_addr;
            cur_wdata  <= sel_wdata[TIME_W-1:0];
            last_grant <= gnt_id;
            state      <= ST_ACCESS;
            // Registered so the load pulse lands in the ACCESS cycle.
            if (sel_wr && sel_addr == ADDR_TIME) begin
              rtc_load     <= 1'b1;
              rtc_load_val <= {{(BUS_64-TIME_W){1'b0}}, sel_wdata[TIME_W-1:0]};
            end
          end
        end
        ST_ACCESS: begin
          resp_valid <= 1'b1;
          resp_id    <= cur_id;
          resp_rdata <= rd_mux;
          state      <= ST_RESP;
          if (acc_wr && cur_addr == ADDR_PRESCALE)
            prescale <= (cur_wdata[CNT_W-1:0] == '0) ? CNT_W'(1) : cur_wdata[CNT_W-1:0];
          if (acc_wr && cur_addr == ADDR_CTRL)
            run <= cur_wdata[0];
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ysyx_210544_rtc_prescaler #(.CNT_W(CNT_W)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .clear    (cnt_clear),
    .prescale (prescale),
    .tick     (rtc_tick)
  );

`ifdef RTC_ALARM_EN
  logic              alarm_en;
  logic [TIME_W-1:0] alarm;
  logic              alarm_chk;

  assign alarm_en_rd = alarm_en;
  assign alarm_rd    = alarm;

  // rtc_val reflects a tick/load one cycle later, so the compare is delayed to match.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_en  <= 1'b0;
      alarm     <= '0;
      alarm_chk <= 1'b0;
      alarm_irq <= 1'b0;
    end else begin
      alarm_chk <= rtc_tick | rtc_load;
      if (acc_wr && cur_addr == ADDR_CTRL)
        alarm_en <= cur_wdata[1];
      if (acc_wr && cur_addr == ADDR_ALARM)
        alarm <= cur_wdata;
      if (alarm_en && alarm_chk && rtc_val[TIME_W-1:0] == alarm)
        alarm_irq <= 1'b1;
      else if (acc_wr && cur_addr == ADDR_CTRL && cur_wdata[2])
        alarm_irq <= 1'b0;
    end
  end
`else
  assign alarm_en_rd = 1'b0;
  assign alarm_rd    = '0;
  assign alarm_irq   = 1'b0;
`endif

  assign unused_bits = &{1'b0, sel_wdata[BUS_64-1:TIME_W], cur_wdata};

endmodule

// File: tb/tb_ysyx_210544_rtc_ctrl.sv
// Directed bench for ysyx_210544_rtc_ctrl: register vector table plus arbitration, stall, tick and reset sequences.
module tb_ysyx_210544_rtc_ctrl;
  import ysyx_210544_rtc_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   req_valid = '0;
  logic [1:0]   req_ready;
  logic [1:0]   req_wr = '0;
  logic [3:0]   req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic         resp_id;
  logic [63:0]  resp_rdata;
  logic [63:0]  rtc_val = '0;
  logic         rtc_tick;
  logic         rtc_load;
  logic [63:0]  rtc_load_val;
  logic         alarm_irq;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tick_q[$];
  int load_q[$];
  logic [63:0] load_val_last = '0;

`ifdef RTC_ALARM_EN
  localparam bit ALARM_BUILD = 1'b1;
`else
  localparam bit ALARM_BUILD = 1'b0;
`endif

  ysyx_210544_rtc_ctrl #(.PRESCALE_RST(100), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wr       (req_wr),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_rdata   (resp_rdata),
    .rtc_val      (rtc_val),
    .rtc_tick     (rtc_tick),
    .rtc_load     (rtc_load),
    .rtc_load_val (rtc_load_val),
    .alarm_irq    (alarm_irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Toy calendar core: a plain counter that loads or advances by one.
  always @(posedge clk) begin
    if (rtc_load)      rtc_val <= rtc_load_val;
    else if (rtc_tick) rtc_val <= rtc_val + 64'd1;
  end

  always @(negedge clk) begin
    if (rtc_tick) tick_q.push_back(cyc);
    if (rtc_load) begin
      load_q.push_back(cyc);
      load_val_last = rtc_load_val;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int id, input bit wr, input logic [1:0] addr, input logic [63:0] wdata);
    req_valid[id]        = 1'b1;
    req_wr[id]           = wr;
    req_addr[id*2 +: 2]  = addr;
    req_wdata[id*64 +: 64] = wdata;
  endtask

  // Called at a negedge; returns at the negedge after the response is consumed.
  task automatic txn(input int id, input bit wr, input logic [1:0] addr, input logic [63:0] wdata,
                     input logic [63:0] exp, input string nm, output int hs);
    int w;
    drive(id, wr, addr, wdata);
    #1;
    w = 0;
    while (!req_ready[id] && w < 20) begin @(negedge clk); #1; w++; end
    chk({nm, " ready"}, 64'(req_ready[id]), 64'd1);
    hs = cyc;
    @(negedge clk);
    req_valid[id] = 1'b0;
    w = 0;
    while (!resp_valid && w < 20) begin @(negedge clk); w++; end
    chk({nm, " latency"}, 64'(cyc - hs), 64'd2);
    chk({nm, " id"}, 64'(resp_id), 64'(id));
    chk({nm, " rdata"}, resp_rdata, exp);
    @(negedge clk);
  endtask

  typedef struct {
    int          id;
    bit          wr;
    logic [1:0]  addr;
    logic [63:0] wdata;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int hs, t0, w;
    logic [63:0] tpack, tload, stk_rd;
    logic        stk_id;

    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int hs, t0, w;
    logic [63:0] tpack, tload, stk_rd, alarm_v;
    logic        stk_id;

    tpack = rtc_pack(16'd2021, 4'd12, 5'd31, 6'd23, 6'd59, 6'd58);
    tload = rtc_pack(16'd2022, 4'd3, 5'd4, 6'd5, 6'd6, 6'd7);

    vecs[0]  = '{0, 1'b1, ADDR_PRESCALE, 64'd7, 64'd0};
    vecs[1]  = '{1, 1'b0, ADDR_PRESCALE, 64'd0, 64'd7};
    vecs[2]  = '{0, 1'b1, ADDR_ALARM, 64'h0123_4567, 64'd0};
    vecs[3]  = '{1, 1'b0, ADDR_ALARM, 64'd0, ALARM_BUILD ? 64'h0123_4567 : 64'd0};
    vecs[4]  = '{0, 1'b1, ADDR_CTRL, 64'h6, 64'd0};
    vecs[5]  = '{0, 1'b0, ADDR_CTRL, 64'd0, ALARM_BUILD ? 64'd2 : 64'd0};
    vecs[6]  = '{1, 1'b1, ADDR_CTRL, 64'd0, 64'd0};
    vecs[7]  = '{1, 1'b0, ADDR_CTRL, 64'd0, 64'd0};
    vecs[8]  = '{0, 1'b1, ADDR_TIME, tpack, 64'd0};
    vecs[9]  = '{1, 1'b0, ADDR_TIME, 64'd0, tpack};
    vecs[10] = '{0, 1'b1, ADDR_PRESCALE, 64'd0, 64'd0};
    vecs[11] = '{0, 1'b0, ADDR_PRESCALE, 64'd0, 64'd1};
    vecs[12] = '{1, 1'b1, ADDR_PRESCALE, 64'd100, 64'd0};

    // Reset with both requesters already asking: nothing may be accepted.
    req_valid = 2'b11;
    #1 rst = 1'b0;
    #2;
    chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst resp_valid", 64'(resp_valid), 64'd0);
    chk("rst resp_id", 64'(resp_id), 64'd0);
    chk("rst resp_rdata", resp_rdata, 64'd0);
    chk("rst rtc_tick", 64'(rtc_tick), 64'd0);
    chk("rst rtc_load", 64'(rtc_load), 64'd0);
    chk("rst rtc_load_val", rtc_load_val, 64'd0);
    chk("rst alarm_irq", 64'(alarm_irq), 64'd0);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Simultaneous requests out of reset: req0 first, then req1.
    drive(0, 1'b0, ADDR_PRESCALE, 64'd0);
    drive(1, 1'b0, ADDR_CTRL, 64'd0);
    #1;
    chk("arb first grant", 64'(req_ready), 64'b01);
    hs = cyc;
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    chk("arb busy ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("arb r0 latency", 64'(cyc - hs), 64'd2);
    chk("arb r0 valid", 64'(resp_valid), 64'd1);
    chk("arb r0 id", 64'(resp_id), 64'd0);
    chk("arb r0 rdata", resp_rdata, 64'd100);
    @(negedge clk);
    #1;
    chk("arb second grant", 64'(req_ready), 64'b10);
    hs = cyc;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    chk("arb r1 latency", 64'(cyc - hs), 64'd2);
    chk("arb r1 id", 64'(resp_id), 64'd1);
    chk("arb r1 rdata", resp_rdata, 64'd0);
    @(negedge clk);

    for (int i = 0; i < 13; i++)
      txn(vecs[i].id, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp, $sformatf("vec%0d", i), hs);
    chk("vec alarm_irq", 64'(alarm_irq), 64'd0);

    // Response stalled for 5 cycles while the other requester waits.
    resp_ready = 1'b0;
    drive(1, 1'b0, ADDR_PRESCALE, 64'd0);
    #1;
    chk("stall grant", 64'(req_ready), 64'b10);
    @(negedge clk);
    req_valid[1] = 1'b0;
    drive(0, 1'b0, ADDR_CTRL, 64'd0);
    @(negedge clk);
    chk("stall valid", 64'(resp_valid), 64'd1);
    chk("stall rdata", resp_rdata, 64'd100);
    chk("stall id", 64'(resp_id), 64'd1);
    stk_rd = resp_rdata;
    stk_id = resp_id;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("stall%0d valid", i), 64'(resp_valid), 64'd1);
      chk($sformatf("stall%0d rdata", i), resp_rdata, 64'd100);
      chk($sformatf("stall%0d id", i), 64'(resp_id), 64'(stk_id));
      chk($sformatf("stall%0d ready", i), 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("stall release grant", 64'(req_ready), 64'b01);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("stall r0 id", 64'(resp_id), 64'd0);
    chk("stall r0 rdata", resp_rdata, 64'd0);
    chk("stall r0 held", stk_rd, 64'd100);
    @(negedge clk);

    // Prescaler: period 4 while running.
    txn(0, 1'b1, ADDR_PRESCALE, 64'd4, 64'd0, "p4 wr", hs);
    txn(0, 1'b1, ADDR_CTRL, 64'd1, 64'd0, "run wr", hs);
    #1 tick_q.delete();
    repeat (16) @(negedge clk);
    #1;
    chk("p4 tick count", 64'(tick_q.size()), 64'd4);
    for (int i = 1; i < tick_q.size(); i++)
      chk($sformatf("p4 gap%0d", i), 64'(tick_q[i] - tick_q[i-1]), 64'd4);

    // TIME write landing on a would-be tick cycle.
    tick_q.delete();
    w = 0;
    while (tick_q.size() == 0 && w < 20) begin @(negedge clk); #1; w++; end
    chk("t3 sync tick", 64'(tick_q.size()), 64'd1);
    t0 = cyc;
    repeat (3) @(negedge clk);
    load_q.delete();
    txn(1, 1'b1, ADDR_TIME, {21'h1F_FFFF, tload[42:0]}, 64'd0, "t3 wr", hs);
    repeat (6) @(negedge clk);
    #1;
    chk("t3 handshake", 64'(hs), 64'(t0 + 3));
    chk("t3 load count", 64'(load_q.size()), 64'd1);
    if (load_q.size() > 0) chk("t3 load cycle", 64'(load_q[0]), 64'(hs + 1));
    chk("t3 load val", load_val_last, tload);
    chk("t3 ticks", 64'(tick_q.size() >= 2), 64'd1);
    if (tick_q.size() >= 2) chk("t3 next tick", 64'(tick_q[1]), 64'(t0 + 8));

    txn(0, 1'b1, ADDR_CTRL, 64'd0, 64'd0, "stop wr", hs);
    #1 tick_q.delete();
    repeat (10) @(negedge clk);
    #1;
    chk("stop ticks", 64'(tick_q.size()), 64'd0);

    // PRESCALE=0 stores 1: tick every cycle.
    txn(1, 1'b1, ADDR_PRESCALE, 64'd0, 64'd0, "p0 wr", hs);
    txn(1, 1'b0, ADDR_PRESCALE, 64'd0, 64'd1, "p0 rd", hs);
    txn(0, 1'b1, ADDR_CTRL, 64'd1, 64'd0, "p0 run", hs);
    #1 tick_q.delete();
    repeat (6) @(negedge clk);
    #1;
    chk("p0 tick count", 64'(tick_q.size()), 64'd6);
    txn(0, 1'b1, ADDR_CTRL, 64'd0, 64'd0, "p0 stop", hs);
    txn(0, 1'b1, ADDR_PRESCALE, 64'd4, 64'd0, "p4 again", hs);

`ifdef RTC_ALARM_EN
    alarm_v = rtc_val + 64'd1;
    txn(0, 1'b1, ADDR_ALARM, alarm_v, 64'd0, "al wr", hs);
    txn(0, 1'b1, ADDR_CTRL, 64'd3, 64'd0, "al en", hs);
    tick_q.delete();
    w = 0;
    while (tick_q.size() == 0 && w < 20) begin @(negedge clk); #1; w++; end
    chk("al tick seen", 64'(tick_q.size()), 64'd1);
    chk("al irq at tick", 64'(alarm_irq), 64'd0);
    @(negedge clk);
    #1;
    chk("al irq tick+1", 64'(alarm_irq), 64'd0);
    @(negedge clk);
    #1;
    chk("al irq tick+2", 64'(alarm_irq), 64'd1);
    repeat (3) @(negedge clk);
    chk("al irq sticky", 64'(alarm_irq), 64'd1);
    txn(1, 1'b1, ADDR_CTRL, 64'd4, 64'd0, "al clr", hs);
    chk("al irq cleared", 64'(alarm_irq), 64'd0);
`else
    txn(0, 1'b1, ADDR_CTRL, 64'd3, 64'd0, "al en", hs);
    repeat (10) @(negedge clk);
    chk("no alarm irq", 64'(alarm_irq), 64'd0);
    txn(1, 1'b0, ADDR_CTRL, 64'd0, 64'd1, "ctrl no bit1", hs);
    txn(0, 1'b1, ADDR_CTRL, 64'd0, 64'd0, "al off", hs);
`endif

    // Reset asserted while a response is pending.
    resp_ready = 1'b0;
    drive(0, 1'b0, ADDR_PRESCALE, 64'd0);
    w = 0;
    while (!resp_valid && w < 20) begin @(negedge clk); w++; end
    chk("mid valid", 64'(resp_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid req_ready", 64'(req_ready), 64'd0);
    chk("mid resp_valid", 64'(resp_valid), 64'd0);
    chk("mid resp_id", 64'(resp_id), 64'd0);
    chk("mid resp_rdata", resp_rdata, 64'd0);
    chk("mid rtc_tick", 64'(rtc_tick), 64'd0);
    chk("mid rtc_load", 64'(rtc_load), 64'd0);
    chk("mid rtc_load_val", rtc_load_val, 64'd0);
    chk("mid alarm_irq", 64'(alarm_irq), 64'd0);
    @(negedge clk);
    req_valid = 2'b00;
    resp_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post rst no resp", 64'(resp_valid), 64'd0);
    txn(0, 1'b0, ADDR_PRESCALE, 64'd0, 64'd100, "post rst prescale", hs);
    txn(1, 1'b0, ADDR_CTRL, 64'd0, 64'd0, "post rst ctrl", hs);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
